// File: rtl/fxp8s_pe_host_if.sv
// Host <-> PE streaming interface: row beats out to the PE, result rows back.
// The host (fxp8s_pe_host) uses the master modport and the PE uses the slave modport.
interface fxp8s_pe_host_if;
  logic        en_in_data;
  logic        rdy_in_data;
  logic        in_mat;
  logic        in_mat_done;
  logic [15:0] in_data;
  logic        en_out_data;
  logic        rdy_out_data;
  logic        out_mat_done;
  logic [15:0] out_data;

  modport master (
    output en_in_data,
    output in_mat,
    output in_mat_done,
    output in_data,
    output rdy_out_data,
    input  rdy_in_data,
    input  en_out_data,
    input  out_mat_done,
    input  out_data
  );

  modport slave (
    input  en_in_data,
    input  in_mat,
    input  in_mat_done,
    input  in_data,
    input  rdy_out_data,
    output rdy_in_data,
    output en_out_data,
    output out_mat_done,
    output out_data
  );
endinterface

// File: rtl/fxp8s_pe_host.sv
// Host for a 2x2 FXP8S PE: holds matrices A/B, streams their rows, collects the result rows.
// Optional stall watchdog with err output when FXP8S_HOST_TIMEOUT_EN is defined.
module fxp8s_pe_host (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cfg_we,
  input  logic [2:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  input  logic       start,
  output logic       busy,
  output logic       done,
  fxp8s_pe_host_if.master pe,
  input  logic [1:0] res_addr,
  output logic [7:0] res_data
`ifdef FXP8S_HOST_TIMEOUT_EN
  ,
  output logic       err
`endif
);

  typedef enum logic [1:0] {StIdle, StSend, StRecv, StDone} state_e;

  state_e     state_q, state_d;
  logic [1:0] beat_q, beat_d;
  logic       row_q, row_d;
  logic [7:0] mat_q [8];
  logic [7:0] res_q [4];
  logic       send, beat_fire, res_fire, timeout;

  assign send      = (state_q == StSend);
  assign beat_fire = send & pe.rdy_in_data;
  assign res_fire  = (state_q == StRecv) & pe.en_out_data;

`ifdef FXP8S_HOST_TIMEOUT_EN
  logic [7:0] stall_q, stall_d;
  logic       err_q, err_d;

  assign timeout = ((state_q == StSend) | (state_q == StRecv)) & ~(beat_fire | res_fire) &
                   (stall_q == 8'hFF);
  assign err     = err_q;

  always_comb begin
    stall_d = stall_q;
    err_d   = err_q;
    if ((state_d != state_q) || beat_fire || res_fire) begin
      stall_d = '0;
    end else if ((state_q == StSend) || (state_q == StRecv)) begin
      stall_d = stall_q + 8'd1;
    end
    if (timeout) begin
      err_d = 1'b1;
    end else if ((state_q == StIdle) && start) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    row_d   = row_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSend;
          beat_d  = '0;
          row_d   = 1'b0;
        end
      end
      StSend: begin
        if (beat_fire) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = StRecv;
        end
      end
      StRecv: begin
        if (res_fire) begin
          row_d = ~row_q;
          if (pe.out_mat_done) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (timeout) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      beat_q  <= '0;
      row_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      row_q   <= row_d;
    end
  end

  // Matrix registers are only writable while idle so a running stream never changes under the PE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 8; i++) mat_q[i] <= '0;
    end else if (cfg_we && (state_q == StIdle)) begin
      mat_q[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) res_q[i] <= '0;
    end else if (res_fire) begin
      res_q[{row_q, 1'b0}] <= pe.out_data[7:0];
      res_q[{row_q, 1'b1}] <= pe.out_data[15:8];
    end
  end

  // Beat index is {matrix, row}; beat data only changes when a beat is accepted.
  assign pe.en_in_data   = send;
  assign pe.in_mat       = send & beat_q[1];
  assign pe.in_mat_done  = send & beat_q[0];
  assign pe.in_data      = send ? {mat_q[{beat_q, 1'b1}], mat_q[{beat_q, 1'b0}]} : 16'h0000;
  assign pe.rdy_out_data = (state_q == StRecv);

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign res_data = res_q[res_addr];

endmodule

// File: tb/tb_fxp8s_pe_host.sv
// Directed self-checking bench for fxp8s_pe_host (define FXP8S_HOST_TIMEOUT_EN for the watchdog).
module tb_fxp8s_pe_host;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [7:0] cfg_wdata = '0;
  logic       start = 1'b0;
  logic       busy, done;
  logic [1:0] res_addr = '0;
  logic [7:0] res_data;
`ifdef FXP8S_HOST_TIMEOUT_EN
  logic       err;
`endif

  int total = 0;
  int bad = 0;

  logic [15:0] exp_beat [4] = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};

  fxp8s_pe_host_if pe_if ();

  fxp8s_pe_host dut (
    .clk       (clk),
    .rstn      (rstn),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pe        (pe_if.master),
    .res_addr  (res_addr),
    .res_data  (res_data)
`ifdef FXP8S_HOST_TIMEOUT_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic load_mats();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cfg_we    = 1'b1;
      cfg_addr  = 3'(i);
      cfg_wdata = 8'(i + 1);
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    pe_if.rdy_in_data  = 1'b0;
    pe_if.en_out_data  = 1'b0;
    pe_if.out_mat_done = 1'b0;
    pe_if.out_data     = '0;
    #12;
    total++;
    if ({busy, done, pe_if.en_in_data, pe_if.in_mat, pe_if.in_mat_done, pe_if.rdy_out_data}
        !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 000000", {busy, done, pe_if.en_in_data,
               pe_if.in_mat, pe_if.in_mat_done, pe_if.rdy_out_data});
    end
    total++;
    if (pe_if.in_data !== 16'h0000) begin
      bad++;
      $display("FAIL reset_in_data: got %h want 0000", pe_if.in_data);
    end
    for (int a = 0; a < 4; a++) begin
      res_addr = 2'(a);
      #1;
      total++;
      if (res_data !== 8'h00) begin
        bad++;
        $display("FAIL reset_res[%0d]: got %h want 00", a, res_data);
      end
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_stream();
    logic [7:0] exp_res [4] = '{8'h10, 8'h13, 8'h22, 8'h2B};
    load_mats();
    @(negedge clk);
    start = 1'b1;
    pe_if.rdy_in_data = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      total++;
      if ({pe_if.en_in_data, pe_if.in_mat, pe_if.in_mat_done, pe_if.in_data} !==
          {1'b1, (b >= 2), (b % 2 == 1), exp_beat[b]}) begin
        bad++;
        $display("FAIL stream_beat%0d: got en=%b mat=%b md=%b data=%h want en=1 mat=%0d md=%0d data=%h",
                 b, pe_if.en_in_data, pe_if.in_mat, pe_if.in_mat_done, pe_if.in_data,
                 (b >= 2), (b % 2), exp_beat[b]);
      end
      @(negedge clk);
    end
    pe_if.rdy_in_data = 1'b0;
    total++;
    if ({pe_if.en_in_data, pe_if.rdy_out_data, busy} !== 3'b011) begin
      bad++;
      $display("FAIL stream_recv: got en/rdy_out/busy=%b want 011",
               {pe_if.en_in_data, pe_if.rdy_out_data, busy});
    end
    pe_if.en_out_data  = 1'b1;
    pe_if.out_data     = 16'h1310;
    pe_if.out_mat_done = 1'b0;
    @(negedge clk);
    pe_if.out_data     = 16'h2B22;
    pe_if.out_mat_done = 1'b1;
    @(negedge clk);
    pe_if.en_out_data  = 1'b0;
    pe_if.out_mat_done = 1'b0;
    total++;
    if ({done, busy, pe_if.rdy_out_data} !== 3'b110) begin
      bad++;
      $display("FAIL stream_done: got done/busy/rdy_out=%b want 110",
               {done, busy, pe_if.rdy_out_data});
    end
    @(negedge clk);
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++;
      $display("FAIL stream_idle: got done/busy=%b want 00", {done, busy});
    end
    for (int a = 0; a < 4; a++) begin
      res_addr = 2'(a);
      #1;
      total++;
      if (res_data !== exp_res[a]) begin
        bad++;
        $display("FAIL stream_res[%0d]: got %h want %h", a, res_data, exp_res[a]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_res [4] = '{8'h44, 8'h55, 8'h22, 8'h2B};
    @(negedge clk);
    start = 1'b1;
    pe_if.rdy_in_data = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({pe_if.en_in_data, pe_if.in_mat_done, pe_if.in_data} !== {2'b11, 16'h0403}) begin
        bad++;
        $display("FAIL bp_hold%0d: got en=%b md=%b data=%h want en=1 md=1 data=0403",
                 i, pe_if.en_in_data, pe_if.in_mat_done, pe_if.in_data);
      end
      pe_if.rdy_in_data = (i == 3);
      if (i < 3) @(negedge clk);
    end
    @(negedge clk);
    total++;
    if ({pe_if.in_mat, pe_if.in_data} !== {1'b1, 16'h0605}) begin
      bad++;
      $display("FAIL bp_next: got mat=%b data=%h want mat=1 data=0605",
               pe_if.in_mat, pe_if.in_data);
    end
    @(negedge clk);
    @(negedge clk);
    pe_if.rdy_in_data  = 1'b0;
    // a single result beat that already carries out_mat_done
    pe_if.en_out_data  = 1'b1;
    pe_if.out_data     = 16'h5544;
    pe_if.out_mat_done = 1'b1;
    @(negedge clk);
    pe_if.en_out_data  = 1'b0;
    pe_if.out_mat_done = 1'b0;
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL bp_done: got %b want 1", done);
    end
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      res_addr = 2'(a);
      #1;
      total++;
      if (res_data !== exp_res[a]) begin
        bad++;
        $display("FAIL bp_res[%0d]: got %h want %h", a, res_data, exp_res[a]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    @(negedge clk);
    start = 1'b1;
    pe_if.rdy_in_data = 1'b0;
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = 3'd0;
    cfg_wdata = 8'hFF;
    @(negedge clk);
    cfg_we = 1'b0;
    start  = 1'b0;
    pe_if.rdy_in_data = 1'b1;
    for (int b = 0; b < 4; b++) begin
      total++;
      if ({pe_if.en_in_data, pe_if.in_mat, pe_if.in_mat_done, pe_if.in_data} !==
          {1'b1, (b >= 2), (b % 2 == 1), exp_beat[b]}) begin
        bad++;
        $display("FAIL busy_beat%0d: got en=%b mat=%b md=%b data=%h want data=%h",
                 b, pe_if.en_in_data, pe_if.in_mat, pe_if.in_mat_done, pe_if.in_data,
                 exp_beat[b]);
      end
      @(negedge clk);
    end
    pe_if.rdy_in_data  = 1'b0;
    pe_if.en_out_data  = 1'b1;
    pe_if.out_data     = 16'h7766;
    pe_if.out_mat_done = 1'b1;
    start = 1'b1;
    @(negedge clk);
    pe_if.en_out_data  = 1'b0;
    pe_if.out_mat_done = 1'b0;
    start = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL busy_end: got busy/done=%b want 00", {busy, done});
    end
    res_addr = 2'd0;
    #1;
    total++;
    if (res_data !== 8'h66) begin
      bad++;
      $display("FAIL busy_res0: got %h want 66", res_data);
    end
    res_addr = 2'd3;
    #1;
    total++;
    if (res_data !== 8'h2B) begin
      bad++;
      $display("FAIL busy_res3: got %h want 2b", res_data);
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    start = 1'b1;
    pe_if.rdy_in_data = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (pe_if.in_data !== 16'h0605) begin
      bad++;
      $display("FAIL rst_pre: got %h want 0605", pe_if.in_data);
    end
    rstn = 1'b0;
    res_addr = 2'd0;
    #1;
    total++;
    if ({pe_if.en_in_data, pe_if.in_mat, pe_if.in_mat_done, pe_if.rdy_out_data, busy, done,
         pe_if.in_data, res_data} !== 30'h0) begin
      bad++;
      $display("FAIL rst_mid: got en=%b mat=%b md=%b rdy_out=%b busy=%b done=%b data=%h res=%h want all 0",
               pe_if.en_in_data, pe_if.in_mat, pe_if.in_mat_done, pe_if.rdy_out_data, busy,
               done, pe_if.in_data, res_data);
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({pe_if.en_in_data, busy} !== 2'b00) begin
        bad++;
        $display("FAIL rst_quiet%0d: got en/busy=%b want 00", i, {pe_if.en_in_data, busy});
      end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({pe_if.en_in_data, pe_if.in_data} !== {1'b1, 16'h0000}) begin
      bad++;
      $display("FAIL rst_restart: got en=%b data=%h want en=1 data=0000",
               pe_if.en_in_data, pe_if.in_data);
    end
    pe_if.rdy_in_data = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

`ifdef FXP8S_HOST_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    @(negedge clk);
    start = 1'b1;
    pe_if.rdy_in_data = 1'b0;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({busy, err} !== 2'b10) begin
      bad++;
      $display("FAIL to_start: got busy/err=%b want 10", {busy, err});
    end
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    total++;
    if ({busy, err} !== 2'b01 || n < 254 || n > 258) begin
      bad++;
      $display("FAIL to_expire: got busy=%b err=%b after %0d cycles want busy=0 err=1 near 256",
               busy, err, n);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({busy, err} !== 2'b10) begin
      bad++;
      $display("FAIL to_clear: got busy/err=%b want 10", {busy, err});
    end
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_busy_ignore();
    test_reset_midrun();
`ifdef FXP8S_HOST_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fxp8s_pe_host.md
FXP8S_PE_HOST -- requirements
Module: fxp8s_pe_host

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port cfg_we, input, 1, matrix-register write strobe.
REQ-004 SHALL have port cfg_addr, input, 3, element select: [2] matrix (0=A, 1=B), [1] row, [0] col.
REQ-005 SHALL have port cfg_wdata, input, 8, FXP8S element (sign-magnitude, LSB weight 2^-3).
REQ-006 SHALL have port start, input, 1, run request.
REQ-007 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-008 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-009 SHALL have port en_in_data, output, 1, transmit beat valid.
REQ-010 SHALL have port rdy_in_data, input, 1, PE input accept.
REQ-011 SHALL have port in_mat, output, 1, matrix tag (0=A, 1=B).
REQ-012 SHALL have port in_mat_done, output, 1, last row of current matrix.
REQ-013 SHALL have port in_data, output, 16, row beat: [7:0] col 0, [15:8] col 1.
REQ-014 SHALL have port en_out_data, input, 1, result beat valid.
REQ-015 SHALL have port rdy_out_data, output, 1, result accept.
REQ-016 SHALL have port out_mat_done, input, 1, last result row.
REQ-017 SHALL have port out_data, input, 16, result row: [7:0] col 0, [15:8] col 1.
REQ-018 SHALL have port res_addr, input, 2, result element select: [1] row, [0] col.
REQ-019 SHALL have port res_data, output, 8, combinational read of the selected result register.

Function
REQ-020 SHALL use FSM states IDLE, SEND, RECV, DONE.
REQ-021 SHALL move IDLE->SEND on start; SHALL ignore start in all other states.
REQ-022 SHALL write cfg_wdata to the cfg_addr element on cfg_we only in IDLE; writes in other states SHALL be dropped.
REQ-023 SHALL, in SEND, drive en_in_data=1 and step a 2-bit beat counter through four beats in order: A row0, A row1, B row0, B row1.
REQ-024 SHALL set in_mat = beat[1], and in_data = {M[r][1], M[r][0]} with r = beat[0].
REQ-025 SHALL assert in_mat_done together with the row-1 beat of each matrix, and drive it low otherwise.
REQ-026 SHALL complete a beat only in a cycle with en_in_data & rdy_in_data both high.
REQ-027 SHALL hold in_data, in_mat and in_mat_done stable until the beat completes; en_in_data SHALL NOT depend combinationally on rdy_in_data.
REQ-028 SHALL move SEND->RECV in the cycle after beat 3 completes; en_in_data SHALL be 0 outside SEND.
REQ-029 SHALL drive rdy_out_data=1 only in RECV.
REQ-030 SHALL, on each RECV cycle with en_out_data high, capture out_data into result row k (k = 1-bit counter, starting at 0) and increment k.
REQ-031 SHALL move RECV->DONE on a captured beat with out_mat_done=1, even if k=0; rows not received SHALL keep their prior values.
REQ-032 SHALL pulse done=1 for exactly the DONE cycle, then return to IDLE.
REQ-033 SHALL keep the matrix registers unchanged across runs, so start may be reissued without reload.
REQ-034 SHALL keep the result registers until overwritten by a later capture.

Reset
REQ-035 SHALL, while rstn=0, force: state IDLE; counters 0; en_in_data, in_mat, in_mat_done, rdy_out_data, busy, done all 0; in_data 0; matrix and result registers 0.
REQ-036 SHALL abandon a run when reset is asserted mid-run, with no further beats after rstn rises until a new start.

Configuration
REQ-037 SHALL add, when FXP8S_HOST_TIMEOUT_EN is defined, an output err (1 bit, reset 0) and an 8-bit stall counter.
REQ-038 With the macro: the counter SHALL clear on any completed beat or state change and increment each SEND/RECV cycle with no completion.
REQ-039 With the macro: when the counter reaches 255, the FSM SHALL go to IDLE and set err=1; err SHALL clear on the next accepted start.
REQ-040 Without the macro: no err port and no counter; the FSM SHALL wait indefinitely.

Verification
REQ-041 Load A=[[0x01,0x02],[0x03,0x04]] and B=[[0x05,0x06],[0x07,0x08]], start with rdy_in_data=1 -> beats 0x0201/mat0/done0, 0x0403/mat0/done1, 0x0605/mat1/done0, 0x0807/mat1/done1 on consecutive cycles.
REQ-042 Hold rdy_in_data=0 for 3 cycles on beat 1 -> en_in_data=1 and in_data=0x0403 held for all 3 cycles; beat completes on the first rdy=1 cycle.
REQ-043 In RECV, supply out_data 0x1310, then 0x2B22 with out_mat_done=1 -> res_data reads 0x10, 0x13, 0x22, 0x2B at res_addr 0..3; done pulses one cycle.
REQ-044 Deassert rstn during beat 2 -> all outputs 0 immediately; after release, no beats until start.
REQ-045 With FXP8S_HOST_TIMEOUT_EN, keep rdy_in_data=0 after start -> err=1 and busy=0 after 255 stalled cycles; next start clears err.
REQ-046 Apply start and cfg_we while busy -> both ignored; matrix contents and beat sequence unchanged.
